rounding_divider_pipe: RTL

ROUNDING_DIVIDER_PIPE -- requirements
Module: rounding_divider_pipe

---
 rtl/rounding_pkg.sv | 14 +
 rtl/rounding_round_unit.sv | 31 +++
 rtl/rounding_divider_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/rounding_pkg.sv
// rounding_pkg: shared types for the rounding divider pipeline.
//   round_mode_e : rounding mode encoding carried on the 2-bit mode input.
package rounding_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,  // floor
    RND_HALF_UP   = 2'd1,  // ties go up
    RND_HALF_EVEN = 2'd2,  // ties go to the even quotient
    RND_CEIL      = 2'd3   // any nonzero remainder goes up
  } round_mode_e;

  localparam int STAGES = 2;

endpackage

// File: rtl/rounding_round_unit.sv
// rounding_round_unit: combinational round-up decision.
//   mode   : rounding mode
//   rem_nz : any discarded bit set
//   half   : most significant discarded bit (weight 1/2)
//   sticky : any discarded bit below the half bit
//   lsb    : LSB of the truncated quotient
//   up     : add one to the truncated quotient
module rounding_round_unit
  import rounding_pkg::*;
(
  input  round_mode_e mode,
  input  logic        rem_nz,
  input  logic        half,
  input  logic        sticky,
  input  logic        lsb,
  output logic        up
);

  always_comb begin
    up = 1'b0;
    case (mode)
      RND_TRUNC:     up = 1'b0;
      RND_HALF_UP:   up = half;
      // exact tie (half set, nothing below) rounds only when lsb is odd
      RND_HALF_EVEN: up = half & (sticky | lsb);
      RND_CEIL:      up = rem_nz;
      default:       up = 1'b0;
    endcase
  end

endmodule

// File: rtl/rounding_divider_pipe.sv
// rounding_divider_pipe: two-stage elastic pipeline computing
// round(din / 2^shift) with saturation to OUT_WIDTH bits.
//   clk, reset            : clock, synchronous active-high reset
//   din/shift/mode        : dividend, log2 divisor, rounding mode
//   din_valid/din_ready   : input handshake
//   dout/dout_sat         : rounded quotient, clamp flag
//   dout_valid/dout_ready : output handshake
//   sat_count/sat_clear   : saturating count of consumed clamped beats, clear
module rounding_divider_pipe
  import rounding_pkg::*;
#(
  parameter int IN_WIDTH  = 35,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT_W   = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic [1:0]           mode,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_sat,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [CNT_W-1:0]     sat_count,
  input  logic                 sat_clear
);

  // vld_pipe[0] is the accept strobe, [1]/[2] are the stage occupancy bits
  logic [STAGES:0] vld_pipe;
  logic            ld1, ld2, adv2;

  assign adv2        = vld_pipe[2] & dout_ready;
  assign ld2         = vld_pipe[1] & (~vld_pipe[2] | dout_ready);
  assign din_ready   = ~reset & (~vld_pipe[1] | ld2);
  assign ld1         = din_valid & din_ready;
  assign vld_pipe[0] = ld1;

  // ---- stage 1: truncated quotient and round-up bit ----
  logic [IN_WIDTH-1:0] mask_lo, rem, q_c;
  logic                rem_nz, half, sticky, up_c;

  always_comb begin
    mask_lo = ~({IN_WIDTH{1'b1}} << shift);
    rem     = din & mask_lo;
    q_c     = din >> shift;
    rem_nz  = |rem;
    // top bit of the mask is the half position; shift=0 gives an empty mask
    half    = |(rem & (mask_lo ^ (mask_lo >> 1)));
    sticky  = |(rem & (mask_lo >> 1));
  end

  rounding_round_unit u_round (
    .mode   (round_mode_e'(mode)),
    .rem_nz (rem_nz),
    .half   (half),
    .sticky (sticky),
    .lsb    (q_c[0]),
    .up     (up_c)
  );

  logic [IN_WIDTH-1:0] q1;
  logic                up1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      q1          <= '0;
      up1         <= 1'b0;
    end else begin
      vld_pipe[1] <= ld1 | (vld_pipe[1] & ~ld2);
      if (ld1) begin
        q1  <= q_c;
        up1 <= up_c;
      end
    end
  end

  // ---- stage 2: increment and clamp ----
  logic [IN_WIDTH:0]    sum;
  logic                 sat_c;
  logic [OUT_WIDTH-1:0] res_c;

  always_comb begin
    sum   = {1'b0, q1} + {{IN_WIDTH{1'b0}}, up1};
    sat_c = |sum[IN_WIDTH:OUT_WIDTH];
    res_c = sat_c ? {OUT_WIDTH{1'b1}} : sum[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[2] <= 1'b0;
      dout        <= '0;
      dout_sat    <= 1'b0;
    end else begin
      vld_pipe[2] <= ld2 | (vld_pipe[2] & ~dout_ready);
      if (ld2) begin
        dout     <= res_c;
        dout_sat <= sat_c;
      end
    end
  end

  assign dout_valid = vld_pipe[2];

  // ---- saturation counter: clear wins, holds at all-ones ----
  always_ff @(posedge clk) begin
    if (reset || sat_clear)
      sat_count <= '0;
    else if (adv2 && dout_sat && (sat_count != {CNT_W{1'b1}}))
      sat_count <= sat_count + 1'b1;
  end

endmodule
